// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters.
//   Round-robin grant, operand and result registering, one op in flight.
//   A watchdog turns a hung ALU op into an error response
//   (rsp_err=1, rsp_out=32'h2BADDEAD).
// Parameters:
//   TIMEOUT_CYC : WAIT cycles before abort (0 disables the watchdog)
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_vld/rdy, reqN_A/B/sel    request channel of port N (N=0,1)
//   rspN_vld/rdy                  response handshake of port N
//   rsp_out, rsp_eq/gt/ge/set     registered result and flags (shared)
//   rsp_err                       watchdog abort marker
//   ALU_A/B/sel, ALU_en           operands and one-cycle issue pulse to the ALU
//   ALU_vld, ALU_out, ALU_eq/gt/ge/set  result from the ALU
//   ALU_ack                       result consumed (also acks stray results)
// Optional (macro ALU_ARB_STATS_EN):
//   gnt_cnt0/gnt_cnt1 (32b) accepted requests per port, tmo_cnt (16b) aborts;
//   saturating, cleared by rst.
module alu_arbiter #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_vld,
  output logic        req0_rdy,
  input  logic [31:0] req0_A,
  input  logic [31:0] req0_B,
  input  logic [3:0]  req0_sel,
  input  logic        req1_vld,
  output logic        req1_rdy,
  input  logic [31:0] req1_A,
  input  logic [31:0] req1_B,
  input  logic [3:0]  req1_sel,
  output logic        rsp0_vld,
  input  logic        rsp0_rdy,
  output logic        rsp1_vld,
  input  logic        rsp1_rdy,
  output logic [31:0] rsp_out,
  output logic        rsp_eq,
  output logic        rsp_gt,
  output logic        rsp_ge,
  output logic        rsp_set,
  output logic        rsp_err,
  output logic [31:0] ALU_A,
  output logic [31:0] ALU_B,
  output logic [3:0]  ALU_sel,
  output logic        ALU_en,
  input  logic        ALU_vld,
  input  logic [31:0] ALU_out,
  input  logic        ALU_eq,
  input  logic        ALU_gt,
  input  logic        ALU_ge,
  input  logic        ALU_set,
`ifdef ALU_ARB_STATS_EN
  output logic [31:0] gnt_cnt0,
  output logic [31:0] gnt_cnt1,
  output logic [15:0] tmo_cnt,
`endif
  output logic        ALU_ack
);

  localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WDW-1:0] WD_LIM = WDW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_last;
  logic            r_gnt;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [3:0]      r_sel;
  logic [WDW-1:0]  r_wdog;
  logic [31:0]     r_rsp_out;
  logic [3:0]      r_rsp_flg;
  logic            r_rsp_err;

  logic            w_any;
  logic            w_pick;
  logic            w_accept;
  logic            w_capture;
  logic            w_abort;
  logic            w_rsp_hs;

  // Port picked if a grant happens now: the non-last port wins a tie.
  assign w_any  = req0_vld | req1_vld;
  assign w_pick = (req0_vld && req1_vld) ? ~r_last : req1_vld;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req0_rdy  = 1'b0;
    req1_rdy  = 1'b0;
    rsp0_vld  = 1'b0;
    rsp1_vld  = 1'b0;
    ALU_en    = 1'b0;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_abort   = 1'b0;
    w_rsp_hs  = 1'b0;
    case (r_state)
      S_IDLE: begin
        req0_rdy = w_any & ~w_pick;
        req1_rdy = w_any &  w_pick;
        w_accept = w_any;
        if (w_any) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        ALU_en = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (ALU_vld) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end else if ((TIMEOUT_CYC != 0) && (r_wdog == WD_LIM)) begin
          w_abort = 1'b1;
          w_next  = S_RESP;
        end
      end
      S_RESP: begin
        rsp0_vld = ~r_gnt;
        rsp1_vld =  r_gnt;
        w_rsp_hs = r_gnt ? rsp1_rdy : rsp0_rdy;
        if (w_rsp_hs) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Any ALU result is acked: in WAIT it is captured, elsewhere it is a
  // late result of an aborted op and is simply dropped.
  assign ALU_ack = ALU_vld & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last    <= 1'b1;
      r_gnt     <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_sel     <= '0;
      r_wdog    <= '0;
      r_rsp_out <= '0;
      r_rsp_flg <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_gnt <= w_pick;
        r_a   <= w_pick ? req1_A   : req0_A;
        r_b   <= w_pick ? req1_B   : req0_B;
        r_sel <= w_pick ? req1_sel : req0_sel;
      end
      if (r_state == S_ISSUE)     r_wdog <= '0;
      else if (r_state == S_WAIT) r_wdog <= r_wdog + 1'b1;
      if (w_capture) begin
        r_rsp_out <= ALU_out;
        r_rsp_flg <= {ALU_eq, ALU_gt, ALU_ge, ALU_set};
        r_rsp_err <= 1'b0;
      end else if (w_abort) begin
        r_rsp_out <= 32'h2BADDEAD;
        r_rsp_flg <= '0;
        r_rsp_err <= 1'b1;
      end
      if (w_rsp_hs) r_last <= r_gnt;
    end
  end

  assign ALU_A   = r_a;
  assign ALU_B   = r_b;
  assign ALU_sel = r_sel;
  assign rsp_out = r_rsp_out;
  assign rsp_eq  = r_rsp_flg[3];
  assign rsp_gt  = r_rsp_flg[2];
  assign rsp_ge  = r_rsp_flg[1];
  assign rsp_set = r_rsp_flg[0];
  assign rsp_err = r_rsp_err;

`ifdef ALU_ARB_STATS_EN
  logic [31:0] r_gnt_cnt0;
  logic [31:0] r_gnt_cnt1;
  logic [15:0] r_tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt_cnt0 <= '0;
      r_gnt_cnt1 <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      if (w_accept && !w_pick && (r_gnt_cnt0 != '1)) r_gnt_cnt0 <= r_gnt_cnt0 + 1'b1;
      if (w_accept &&  w_pick && (r_gnt_cnt1 != '1)) r_gnt_cnt1 <= r_gnt_cnt1 + 1'b1;
      if (w_abort && (r_tmo_cnt != '1))              r_tmo_cnt  <= r_tmo_cnt + 1'b1;
    end
  end

  assign gnt_cnt0 = r_gnt_cnt0;
  assign gnt_cnt1 = r_gnt_cnt1;
  assign tmo_cnt  = r_tmo_cnt;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: scoreboard of expected responses, checked by a
// monitor on each response handshake. A second instance with an 8-cycle
// watchdog and a silent ALU covers the abort path.
module tb_alu_arbiter;

  // bench-local opcode numbering for the behavioural ALU
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_DIV = 4'hD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0_vld = 0, req1_vld = 0;
  logic        req0_rdy, req1_rdy;
  logic [31:0] req0_A = 0, req0_B = 0, req1_A = 0, req1_B = 0;
  logic [3:0]  req0_sel = 0, req1_sel = 0;
  logic        rsp0_vld, rsp1_vld;
  logic        rsp0_rdy = 1, rsp1_rdy = 1;
  logic [31:0] rsp_out;
  logic        rsp_eq, rsp_gt, rsp_ge, rsp_set, rsp_err;
  logic [31:0] ALU_A, ALU_B;
  logic [3:0]  ALU_sel;
  logic        ALU_en, ALU_ack;
  logic        m_vld = 0;
  logic [31:0] m_out = 0;
  logic [3:0]  m_flg = 0;

  // watchdog instance signals
  logic        t_req0_vld = 0, t_rsp0_rdy = 0, t_alu_vld = 0;
  logic        t_req0_rdy, t_req1_rdy, t_rsp0_vld, t_rsp1_vld;
  logic [31:0] t_rsp_out, t_alu_a, t_alu_b;
  logic        t_eq, t_gt, t_ge, t_set, t_err, t_alu_en, t_alu_ack;
  logic [3:0]  t_alu_sel;

`ifdef ALU_ARB_STATS_EN
  logic [31:0] gnt_cnt0, gnt_cnt1, t_gnt_cnt0, t_gnt_cnt1;
  logic [15:0] tmo_cnt, t_tmo_cnt;
`endif

  alu_arbiter #(.TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst),
    .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_A(req0_A), .req0_B(req0_B), .req0_sel(req0_sel),
    .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_A(req1_A), .req1_B(req1_B), .req1_sel(req1_sel),
    .rsp0_vld(rsp0_vld), .rsp0_rdy(rsp0_rdy), .rsp1_vld(rsp1_vld), .rsp1_rdy(rsp1_rdy),
    .rsp_out(rsp_out), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt), .rsp_ge(rsp_ge), .rsp_set(rsp_set),
    .rsp_err(rsp_err),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_sel(ALU_sel), .ALU_en(ALU_en),
    .ALU_vld(m_vld), .ALU_out(m_out),
    .ALU_eq(m_flg[3]), .ALU_gt(m_flg[2]), .ALU_ge(m_flg[1]), .ALU_set(m_flg[0]),
`ifdef ALU_ARB_STATS_EN
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .tmo_cnt(tmo_cnt),
`endif
    .ALU_ack(ALU_ack)
  );

  alu_arbiter #(.TIMEOUT_CYC(8)) dut_t8 (
    .clk(clk), .rst(rst),
    .req0_vld(t_req0_vld), .req0_rdy(t_req0_rdy), .req0_A(32'h1111), .req0_B(32'h2222), .req0_sel(OP_ADD),
    .req1_vld(1'b0), .req1_rdy(t_req1_rdy), .req1_A(32'h0), .req1_B(32'h0), .req1_sel(4'h0),
    .rsp0_vld(t_rsp0_vld), .rsp0_rdy(t_rsp0_rdy), .rsp1_vld(t_rsp1_vld), .rsp1_rdy(1'b1),
    .rsp_out(t_rsp_out), .rsp_eq(t_eq), .rsp_gt(t_gt), .rsp_ge(t_ge), .rsp_set(t_set),
    .rsp_err(t_err),
    .ALU_A(t_alu_a), .ALU_B(t_alu_b), .ALU_sel(t_alu_sel), .ALU_en(t_alu_en),
    .ALU_vld(t_alu_vld), .ALU_out(32'h0),
    .ALU_eq(1'b0), .ALU_gt(1'b0), .ALU_ge(1'b0), .ALU_set(1'b0),
`ifdef ALU_ARB_STATS_EN
    .gnt_cnt0(t_gnt_cnt0), .gnt_cnt1(t_gnt_cnt1), .tmo_cnt(t_tmo_cnt),
`endif
    .ALU_ack(t_alu_ack)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int rsp_cnt [2] = '{0, 0};

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
    logic [3:0]  flg;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int p, input logic [31:0] d, input logic e, input logic [3:0] f);
    exp_t x;
    x.port = p; x.data = d; x.err = e; x.flg = f;
    exp_q.push_back(x);
  endtask

  // behavioural ALU with a programmable latency (cycles from ALU_en to ALU_vld)
  int          alu_delay = 1;
  bit          unstable  = 0;
  bit          pend      = 0;
  int          cnt       = 0;
  logic [31:0] capA, capB;
  logic [3:0]  capS;

  function automatic logic [31:0] alu_f(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk); #2;
      m_vld = 1'b0;
      if (rst) begin
        pend = 0;
      end else begin
        if (pend) begin
          if (ALU_A !== capA || ALU_B !== capB || ALU_sel !== capS) unstable = 1;
          if (cnt == 0) begin
            m_vld = 1'b1;
            m_out = alu_f(capS, capA, capB);
            m_flg = {capA == capB, capA > capB, capA >= capB, capA < capB};
            pend  = 0;
          end else begin
            cnt--;
          end
        end
        if (ALU_en) begin
          pend = 1; capA = ALU_A; capB = ALU_B; capS = ALU_sel; cnt = alu_delay - 1;
        end
      end
    end
  end

  // response monitor: pops one expectation per response handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp0_vld && rsp1_vld) begin
        n_tests++; n_fail++;
        $display("FAIL rsp_onehot: got both rsp0_vld and rsp1_vld, required at most one");
      end
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? (rsp0_vld && rsp0_rdy) : (rsp1_vld && rsp1_rdy)) begin
          rsp_cnt[p]++;
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_rsp: got response on port %0d, required none", p);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rsp_port", p, e.port);
            check("rsp_out", rsp_out, e.data);
            check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            check("rsp_flags", {28'b0, rsp_eq, rsp_gt, rsp_ge, rsp_set}, {28'b0, e.flg});
          end
        end
      end
    end
  end

  task automatic do_req(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    if (p == 0) begin req0_A = a; req0_B = b; req0_sel = s; req0_vld = 1; end
    else        begin req1_A = a; req1_B = b; req1_sel = s; req1_vld = 1; end
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (p == 0) ? req0_rdy : req1_rdy;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL req%0d_accept_timeout: got rdy=0, required rdy=1", p);
    end
    @(posedge clk); #1;
    if (p == 0) req0_vld = 0; else req1_vld = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int bad;
    int c1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // reset state
    @(negedge clk);
    check("rst_outputs", {26'b0, req0_rdy, req1_rdy, rsp0_vld, rsp1_vld, ALU_en, ALU_ack}, 32'h0);
    check("rst_rsp_out", rsp_out, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);

    // 1: single ADD, latency accept@0, ALU_en@1, rsp0_vld@3
    push_exp(0, 32'd12, 1'b0, 4'b0001);
    @(posedge clk); #1;
    req0_A = 5; req0_B = 7; req0_sel = OP_ADD; req0_vld = 1;
    @(negedge clk); check("t1_accept_c0", {31'b0, req0_rdy}, 32'h1);
    @(posedge clk); #1 req0_vld = 0;
    @(negedge clk); check("t1_en_c1", {30'b0, ALU_en, rsp0_vld}, 32'h2);
    @(negedge clk); check("t1_c2", {30'b0, ALU_en, rsp0_vld}, 32'h0);
    @(negedge clk); check("t1_rsp_c3", {31'b0, rsp0_vld}, 32'h1);
    check("t1_operand", ALU_A, 32'd5);
    wait_drain();

    // 2: both ports always requesting after reset -> 0,1,0,1
    do_reset();
    push_exp(0, 32'd30,  1'b0, 4'b0001);
    push_exp(1, 32'd5,   1'b0, 4'b0110);
    push_exp(0, 32'h30,  1'b0, 4'b0110);
    push_exp(1, 32'hFF,  1'b0, 4'b0001);
    rsp_cnt[0] = 0; rsp_cnt[1] = 0;
    fork
      begin do_req(0, 32'd10, 32'd20, OP_ADD); do_req(0, 32'hF0, 32'h3C, OP_AND); end
      begin do_req(1, 32'd9,  32'd4,  OP_SUB); do_req(1, 32'h0F, 32'hF0, OP_OR);  end
    join
    wait_drain();
    check("t2_port0_count", rsp_cnt[0], 2);
    check("t2_port1_count", rsp_cnt[1], 2);

    // 3: DIV on port 1 with a 20-cycle ALU stall
    alu_delay = 20; unstable = 0; c1 = rsp_cnt[1];
    push_exp(1, 32'd14, 1'b0, 4'b0110);
    do_req(1, 32'd100, 32'd7, OP_DIV);
    wait_drain();
    check("t3_operands_stable", {31'b0, unstable}, 32'h0);
    check("t3_single_rsp", rsp_cnt[1] - c1, 1);
    alu_delay = 1;

    // 5: response back-pressure holds data and blocks the other port
    rsp0_rdy = 0;
    push_exp(0, 32'd42, 1'b0, 4'b0110);
    push_exp(1, 32'd2,  1'b0, 4'b1010);
    fork
      do_req(0, 32'd50, 32'd8, OP_SUB);
      begin @(posedge clk); #1; do_req(1, 32'd1, 32'd1, OP_ADD); end
      begin
        bit seen;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = rsp0_vld; end
        check("t5_rsp0_seen", {31'b0, seen}, 32'h1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (!rsp0_vld || rsp_out !== 32'd42 || req1_rdy) bad++;
        end
        check("t5_hold_cycles_bad", bad, 0);
        @(posedge clk); #1 rsp0_rdy = 1;
      end
    join
    wait_drain();

    // 4: watchdog abort after 8 WAIT cycles, then a late ALU result
    @(posedge clk); #1 t_req0_vld = 1;
    @(negedge clk); check("t4_accept", {31'b0, t_req0_rdy}, 32'h1);
    @(posedge clk); #1 t_req0_vld = 0;
    @(negedge clk); check("t4_en", {31'b0, t_alu_en}, 32'h1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (t_rsp0_vld) bad++; end
    check("t4_early_rsp", bad, 0);
    @(negedge clk);
    check("t4_rsp_vld", {31'b0, t_rsp0_vld}, 32'h1);
    check("t4_rsp_err", {31'b0, t_err}, 32'h1);
    check("t4_rsp_out", t_rsp_out, 32'h2BADDEAD);
    @(posedge clk); #1 t_rsp0_rdy = 1;
    @(posedge clk); #1 t_alu_vld = 1;
    @(negedge clk); check("t4_late_ack", {31'b0, t_alu_ack}, 32'h1);
    @(posedge clk); #1 t_alu_vld = 0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (t_rsp0_vld || t_rsp1_vld) bad++; end
    check("t4_late_no_rsp", bad, 0);
`ifdef ALU_ARB_STATS_EN
    check("t4_tmo_cnt", {16'b0, t_tmo_cnt}, 32'd1);
`endif

    // 6: reset during WAIT drops the op
    alu_delay = 10;
    @(posedge clk); #1;
    req0_A = 3; req0_B = 4; req0_sel = OP_ADD; req0_vld = 1;
    @(negedge clk); check("t6_accept", {31'b0, req0_rdy}, 32'h1);
    @(posedge clk); #1 req0_vld = 0;
    repeat (3) @(negedge clk);
    do_reset();
    @(negedge clk);
    check("t6_after_rst", {26'b0, req0_rdy, req1_rdy, rsp0_vld, rsp1_vld, ALU_en, ALU_ack}, 32'h0);
    check("t6_rsp_out", rsp_out, 32'h0);
`ifdef ALU_ARB_STATS_EN
    check("t6_gnt_cnt0", gnt_cnt0, 32'h0);
    check("t6_gnt_cnt1", gnt_cnt1, 32'h0);
    check("t6_tmo_cnt", {16'b0, tmo_cnt}, 32'h0);
`endif
    alu_delay = 1;
    push_exp(1, 32'd5, 1'b0, 4'b0001);
    @(posedge clk); #1;
    req1_A = 2; req1_B = 3; req1_sel = OP_ADD; req1_vld = 1;
    @(negedge clk); check("t6_idle_accept", {31'b0, req1_rdy}, 32'h1);
    @(posedge clk); #1 req1_vld = 0;
    wait_drain();
    repeat (20) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
